// File: rtl/sd_dsp_pkg.sv
// Shared constants and helpers for the sigma-delta DSP blocks.
package sd_dsp_pkg;

    // Two-bit modulator output codes
    localparam logic [1:0] SD_POS     = 2'b01;
    localparam logic [1:0] SD_NEG     = 2'b11;
    localparam logic [1:0] SD_ZERO    = 2'b00;
    localparam logic [1:0] SD_ILLEGAL = 2'b10;

    localparam int unsigned CIC_ORDER = 3;

    // Results discarded after reset while the comb history fills with real data
    localparam int unsigned CIC_WARMUP_RESULTS = 3;

    // Input is one sign bit plus magnitude 1; each stage grows log2(R) bits
    function automatic int unsigned cic_out_width(input int unsigned decim);
        return 2 + CIC_ORDER * $clog2(decim);
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// Single CIC comb (differentiator, M=1) with a pipeline enable.
module cic_comb_stage #(
    parameter int unsigned Width = 17
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    en_i,
    input  logic signed [Width-1:0] u_i,
    output logic signed [Width-1:0] y_o
);

    logic signed [Width-1:0] prev_q;
    logic signed [Width-1:0] y_q;

    // Difference against the previous enabled input; modular wrap is intended
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q <= '0;
            y_q    <= '0;
        end else if (en_i) begin
            prev_q <= u_i;
            y_q    <= u_i - prev_q;
        end
    end

    assign y_o = y_q;

endmodule

// File: rtl/sd_cic_decimator.sv
// Third-order CIC decimator for the 2-bit sigma-delta stream, with a
// one-deep valid/ready output register and sticky error flags.
module sd_cic_decimator
    import sd_dsp_pkg::*;
#(
    parameter int unsigned DECIM     = 32,
    parameter int unsigned OUT_WIDTH = cic_out_width(DECIM)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic [1:0]                  sd_in,
    output logic signed [OUT_WIDTH-1:0] out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        overrun,
    output logic                        code_err,
    input  logic                        clr_flags
);

    localparam int unsigned CntW = $clog2(DECIM);

    logic signed [OUT_WIDTH-1:0] x;
    logic signed [OUT_WIDTH-1:0] i1_q, i2_q, i3_q;
    logic signed [OUT_WIDTH-1:0] c1, c2, c3;
    logic [CntW-1:0]             cnt_q;
    logic [2:0]                  en_q;
    logic [1:0]                  warm_q;
    logic                        strobe;
    logic                        load;
    logic                        result_new;

    logic signed [OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic                        out_valid_q, out_valid_d;
    logic                        overrun_q, overrun_d;
    logic                        code_err_q, code_err_d;

    // Decode modulator code to {-1, 0, +1}; illegal code contributes nothing
    always_comb begin
        x = '0;
        case (sd_in)
            SD_POS:  x = {{(OUT_WIDTH-1){1'b0}}, 1'b1};
            SD_NEG:  x = '1;
            default: x = '0;
        endcase
    end

    assign strobe = in_valid && (cnt_q == CntW'(DECIM - 1));

    // Integrator cascade and decimation counter, stalled by in_valid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i1_q  <= '0;
            i2_q  <= '0;
            i3_q  <= '0;
            cnt_q <= '0;
        end else if (in_valid) begin
            i1_q  <= i1_q + x;
            i2_q  <= i2_q + i1_q;
            i3_q  <= i3_q + i2_q;
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Enable pipeline: comb k fires on strobe+(k-1), output load on strobe+3
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q <= '0;
        end else begin
            en_q <= {en_q[1:0], strobe};
        end
    end

    cic_comb_stage #(.Width(OUT_WIDTH)) u_comb1 (
        .clk_i (clk),
        .rst_i (reset),
        .en_i  (strobe),
        .u_i   (i3_q),
        .y_o   (c1)
    );

    cic_comb_stage #(.Width(OUT_WIDTH)) u_comb2 (
        .clk_i (clk),
        .rst_i (reset),
        .en_i  (en_q[0]),
        .u_i   (c1),
        .y_o   (c2)
    );

    cic_comb_stage #(.Width(OUT_WIDTH)) u_comb3 (
        .clk_i (clk),
        .rst_i (reset),
        .en_i  (en_q[1]),
        .u_i   (c2),
        .y_o   (c3)
    );

    assign load       = en_q[2];
    assign result_new = load && (warm_q == 2'(CIC_WARMUP_RESULTS));

    // Count discarded warm-up results; saturates once the output goes live
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            warm_q <= '0;
        end else if (load && (warm_q != 2'(CIC_WARMUP_RESULTS))) begin
            warm_q <= warm_q + 1'b1;
        end
    end

    // Output holding register, handshake and sticky flags
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overrun_d   = clr_flags ? 1'b0 : overrun_q;
        code_err_d  = clr_flags ? 1'b0 : code_err_q;
        if (result_new) begin
            out_data_d  = c3;
            out_valid_d = 1'b1;
            if (out_valid_q && !out_ready) begin
                overrun_d = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        // Set events take priority over a same-cycle clear
        if (in_valid && (sd_in == SD_ILLEGAL)) begin
            code_err_d = 1'b1;
        end
    end

    // State registers for the output side
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            code_err_q  <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
            code_err_q  <= code_err_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;
    assign code_err  = code_err_q;

endmodule

// File: doc/sd_cic_decimator.md
Name: sd_cic_decimator

Overview:
Third-order CIC decimation filter that consumes the 2-bit sd_out stream of sigma_delta_twopiece_top. It converts the stream back into multi-bit signed PCM samples at clk/DECIM. It sits directly downstream of the modulator and is used for loopback checking of the modulator's tuning word (kin) and for feeding downstream analysis logic. Output uses a valid/ready handshake with a one-deep holding register.

Parameters:
DECIM, 32, decimation ratio R; must be a power of two, minimum 4.
OUT_WIDTH, 2+3*$clog2(DECIM) (17 at default), signed output width; also the width of every integrator and comb register.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  sd_in qualifier; integrators and decimation counter advance only when high
sd_in  input  2  modulator code: 2'b01=+1, 2'b11=-1, 2'b00=0, 2'b10=illegal (decoded as 0)
out_data  output  OUT_WIDTH  signed decimated sample
out_valid  output  1  out_data holds an unconsumed sample
out_ready  input  1  consumer accepts out_data when out_valid && out_ready
overrun  output  1  sticky: an unconsumed sample was overwritten
code_err  output  1  sticky: 2'b10 was seen with in_valid high
clr_flags  input  1  synchronous clear of overrun and code_err

Behaviour:
- Reset (asynchronous) clears all integrators, combs, the decimation counter, the warm-up counter, out_data, out_valid, overrun and code_err to 0.
- Decode is combinational: sd_in maps to a signed value x in {-1, 0, +1}, sign-extended to OUT_WIDTH.
- Integrators, on each in_valid edge:
  - i1 <= i1 + x; i2 <= i2 + i1; i3 <= i3 + i2 (registered cascade).
  - Modular two's-complement wrap is intended and required; no saturation anywhere.
- Decimation counter: counts 0..DECIM-1 on in_valid and wraps to 0.
  - The strobe is in_valid && cnt==DECIM-1.
  - On the strobe edge, the current i3 register value enters comb stage 1.
- Comb pipeline (M=1): each stage is y = u - u_prev.
  - Stage k registers on edge strobe+(k-1), k=1..3.
  - out_data is loaded on edge strobe+3.
  - Combs advance only on their pipeline enable, never on idle cycles.
- Warm-up: the first 3 decimated results after reset are discarded. out_valid never asserts for them. The first visible sample is the 4th decimated result.
- Handshake:
  - A new result with out_valid==0 loads out_data and sets out_valid.
  - out_valid && out_ready with no new result: out_valid clears next edge; out_data holds.
  - New result with out_valid && out_ready on the same edge: the old sample is consumed, the new one loads, out_valid stays 1, no overrun.
  - New result with out_valid && !out_ready: out_data is overwritten, out_valid stays 1, overrun sets.
- Gain and range:
  - DC gain is DECIM^3 (32768 at default).
  - Full-scale steady state is +DECIM^3 / -DECIM^3, which fits OUT_WIDTH signed.
- Sticky flags:
  - code_err sets when sd_in==2'b10 && in_valid; the illegal code still decodes as 0.
  - clr_flags clears both flags, except that a set event in the same cycle wins.
- in_valid low stalls the integrators and the counter. The comb pipeline and handshake continue draining already-captured results.
- Reset asserted mid-operation aborts everything immediately. After release, warm-up restarts.

Decomposition:
- Shared package sd_dsp_pkg holds:
  - SD_POS=2'b01, SD_NEG=2'b11, SD_ZERO=2'b00, SD_ILLEGAL=2'b10.
  - CIC_ORDER=3.
  - A function cic_out_width(decim) returning 2+CIC_ORDER*$clog2(decim).
- One sub-module, cic_comb_stage (registered differentiator with enable, width parameter), instantiated three times.
- The integrators, counter, warm-up logic and handshake stay in the top module.

Test Plan:
- Constant sd_in=2'b01, in_valid=1, out_ready=1 → first visible out_data after warm-up = +32768, and every following sample = +32768 every 32 clocks; overrun=0.
- Constant 2'b11 → steady-state out_data = -32768. Alternating 01/11 → steady-state 0. Constant 00 → always 0.
- Stimulus from sigma_delta_twopiece_top with kin={16'h0e2c,16'ha000}, out_ready=1 → output mean matches kin/2^32-scaled DC × 32768 within ±1%; code_err=0.
- out_ready=0 across two decimation periods → out_valid held, out_data = latest sample, overrun=1. Then pulse clr_flags → overrun=0.
- Inject one 2'b10 mid-stream → code_err=1 and the decoded contribution is 0. Toggle in_valid 50% → output period becomes 64 clocks with the same steady-state values.
- Assert reset mid-period (cnt=17) → all outputs 0 immediately. After release, 3 results are discarded before out_valid rises again.
